// File: rtl/tiny_alu_arbiter_if.sv
// Requester and ALU handshake bundle for tiny_alu_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface tiny_alu_arbiter_if #(
   parameter int NUM_REQ         = 4,
   parameter int INPUT_DATA_BITS = 8,
   parameter int OPCODE_BITS     = 3
);
   logic [NUM_REQ-1:0]                 req_valid_i;
   logic [NUM_REQ*OPCODE_BITS-1:0]     req_opcode_i;
   logic [NUM_REQ*INPUT_DATA_BITS-1:0] req_a_i;
   logic [NUM_REQ*INPUT_DATA_BITS-1:0] req_b_i;
   logic [NUM_REQ-1:0]                 req_ready_o;
   logic [NUM_REQ-1:0]                 rsp_valid_o;
   logic [2*INPUT_DATA_BITS-1:0]       rsp_result_o;
   logic                               rsp_error_o;
   logic                               alu_start_o;
   logic [OPCODE_BITS-1:0]             alu_opcode_o;
   logic [INPUT_DATA_BITS-1:0]         alu_a_o;
   logic [INPUT_DATA_BITS-1:0]         alu_b_o;
   logic                               alu_done_i;
   logic [2*INPUT_DATA_BITS-1:0]       alu_result_i;
   logic                               busy_o;

   modport slave (
      input  req_valid_i, req_opcode_i, req_a_i, req_b_i, alu_done_i, alu_result_i,
      output req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o,
             alu_start_o, alu_opcode_o, alu_a_o, alu_b_o, busy_o
   );

   modport master (
      output req_valid_i, req_opcode_i, req_a_i, req_b_i, alu_done_i, alu_result_i,
      input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o,
             alu_start_o, alu_opcode_o, alu_a_o, alu_b_o, busy_o
   );
endinterface

// File: rtl/tiny_alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU among NUM_REQ requesters,
// with a per-operation timeout and a one-cycle response pulse to the winner.
module tiny_alu_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int INPUT_DATA_BITS = 8,
   parameter int OPCODE_BITS     = 3,
   parameter int TIMEOUT_CYCLES  = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   tiny_alu_arbiter_if.slave  bus
);
   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RES_W = 2 * INPUT_DATA_BITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t                     state_r, state_n;
   logic [ID_W-1:0]            rr_ptr_r, rr_ptr_n;
   logic [ID_W-1:0]            id_r, id_n;
   logic [CNT_W-1:0]           cnt_r, cnt_n;
   logic                       alu_start_r, alu_start_n;
   logic [OPCODE_BITS-1:0]     alu_opcode_r, alu_opcode_n;
   logic [INPUT_DATA_BITS-1:0] alu_a_r, alu_a_n;
   logic [INPUT_DATA_BITS-1:0] alu_b_r, alu_b_n;
   logic [NUM_REQ-1:0]         rsp_valid_r, rsp_valid_n;
   logic [RES_W-1:0]           rsp_result_r, rsp_result_n;
   logic                       rsp_error_r, rsp_error_n;
   logic                       busy_r, busy_n;

   logic                       found_s;
   logic                       hit_s;
   int                         idx_s;
   logic [ID_W-1:0]            winner_s;
   logic [OPCODE_BITS-1:0]     win_opcode_s;
   logic [INPUT_DATA_BITS-1:0] win_a_s;
   logic [INPUT_DATA_BITS-1:0] win_b_s;
   logic [NUM_REQ-1:0]         ready_s;

   // Round-robin search starting at rr_ptr_r; first valid requester wins.
   always_comb begin
      found_s      = 1'b0;
      hit_s        = 1'b0;
      idx_s        = 0;
      winner_s     = '0;
      win_opcode_s = '0;
      win_a_s      = '0;
      win_b_s      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_s        = (int'(rr_ptr_r) + i) % NUM_REQ;
         hit_s        = !found_s && bus.req_valid_i[idx_s];
         winner_s     = hit_s ? ID_W'(idx_s) : winner_s;
         win_opcode_s = hit_s ? bus.req_opcode_i[idx_s*OPCODE_BITS +: OPCODE_BITS] : win_opcode_s;
         win_a_s      = hit_s ? bus.req_a_i[idx_s*INPUT_DATA_BITS +: INPUT_DATA_BITS] : win_a_s;
         win_b_s      = hit_s ? bus.req_b_i[idx_s*INPUT_DATA_BITS +: INPUT_DATA_BITS] : win_b_s;
         found_s      = found_s | hit_s;
      end
   end

   // Accept pulse is combinational so the requester sees it in the grant cycle.
   always_comb begin
      ready_s = '0;
      if (state_r == IDLE && found_s) begin
         ready_s = NUM_REQ'(1'b1) << winner_s;
      end else begin
         ready_s = '0;
      end
   end

   // Next-state and next-output computation for the arbitration FSM.
   always_comb begin
      state_n      = state_r;
      rr_ptr_n     = rr_ptr_r;
      id_n         = id_r;
      cnt_n        = cnt_r;
      alu_start_n  = 1'b0;
      alu_opcode_n = '0;
      alu_a_n      = '0;
      alu_b_n      = '0;
      rsp_valid_n  = '0;
      rsp_result_n = '0;
      rsp_error_n  = 1'b0;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               id_n     = winner_s;
               rr_ptr_n = (winner_s == ID_W'(NUM_REQ - 1)) ? '0 : winner_s + ID_W'(1);
               if (win_opcode_s != '0) begin
                  state_n      = ISSUE;
                  cnt_n        = CNT_W'(1);
                  alu_start_n  = 1'b1;
                  alu_opcode_n = win_opcode_s;
                  alu_a_n      = win_a_s;
                  alu_b_n      = win_b_s;
               end else begin
                  // no_op bypasses the ALU and answers with a zero result
                  state_n     = RESP;
                  rsp_valid_n = NUM_REQ'(1'b1) << winner_s;
               end
            end else begin
               state_n = IDLE;
            end
         end
         ISSUE: begin
            alu_start_n  = 1'b1;
            alu_opcode_n = alu_opcode_r;
            alu_a_n      = alu_a_r;
            alu_b_n      = alu_b_r;
            if (bus.alu_done_i) begin
               state_n      = RESP;
               cnt_n        = '0;
               alu_start_n  = 1'b0;
               alu_opcode_n = '0;
               alu_a_n      = '0;
               alu_b_n      = '0;
               rsp_valid_n  = NUM_REQ'(1'b1) << id_r;
               rsp_result_n = bus.alu_result_i;
            end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES)) begin
               state_n      = RESP;
               cnt_n        = '0;
               alu_start_n  = 1'b0;
               alu_opcode_n = '0;
               alu_a_n      = '0;
               alu_b_n      = '0;
               rsp_valid_n  = NUM_REQ'(1'b1) << id_r;
               rsp_error_n  = 1'b1;
            end else begin
               cnt_n = cnt_r + CNT_W'(1);
            end
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r      <= IDLE;
         rr_ptr_r     <= '0;
         id_r         <= '0;
         cnt_r        <= '0;
         alu_start_r  <= 1'b0;
         alu_opcode_r <= '0;
         alu_a_r      <= '0;
         alu_b_r      <= '0;
         rsp_valid_r  <= '0;
         rsp_result_r <= '0;
         rsp_error_r  <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_n;
         rr_ptr_r     <= rr_ptr_n;
         id_r         <= id_n;
         cnt_r        <= cnt_n;
         alu_start_r  <= alu_start_n;
         alu_opcode_r <= alu_opcode_n;
         alu_a_r      <= alu_a_n;
         alu_b_r      <= alu_b_n;
         rsp_valid_r  <= rsp_valid_n;
         rsp_result_r <= rsp_result_n;
         rsp_error_r  <= rsp_error_n;
         busy_r       <= busy_n;
      end
   end

   assign bus.req_ready_o  = ready_s;
   assign bus.rsp_valid_o  = rsp_valid_r;
   assign bus.rsp_result_o = rsp_result_r;
   assign bus.rsp_error_o  = rsp_error_r;
   assign bus.alu_start_o  = alu_start_r;
   assign bus.alu_opcode_o = alu_opcode_r;
   assign bus.alu_a_o      = alu_a_r;
   assign bus.alu_b_o      = alu_b_r;
   assign bus.busy_o       = busy_r;

endmodule

// File: tb/tb_tiny_alu_arbiter.sv
// Scoreboard bench for tiny_alu_arbiter: directed requests push expected
// responses, an independent monitor pops and compares on every rsp_valid_o.
module tb_tiny_alu_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   tiny_alu_arbiter_if #(.NUM_REQ(4), .INPUT_DATA_BITS(8), .OPCODE_BITS(3)) bus ();

   tiny_alu_arbiter #(
      .NUM_REQ(4), .INPUT_DATA_BITS(8), .OPCODE_BITS(3), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus.slave)
   );

   typedef struct {
      int          id;
      logic [15:0] res;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   // ALU stand-in controls
   int          alu_lat = 1;      // 0 = never completes
   logic        alu_force = 1'b0;
   logic [15:0] alu_res = 16'h0000;
   int          issue_cnt = 0;
   int          start_cycles = 0;
   logic [2:0]  exp_op = 3'd0;
   logic [7:0]  exp_a = 8'h00;
   logic [7:0]  exp_b = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ALU stand-in: completes after alu_lat start cycles and checks held operands
   always @(negedge clk) begin
      if (rst) begin
         issue_cnt        <= 0;
         bus.alu_done_i   <= 1'b0;
         bus.alu_result_i <= 16'h0000;
      end else if (bus.alu_start_o) begin
         chk("alu_opcode_hold", {29'd0, bus.alu_opcode_o}, {29'd0, exp_op});
         chk("alu_a_hold", {24'd0, bus.alu_a_o}, {24'd0, exp_a});
         chk("alu_b_hold", {24'd0, bus.alu_b_o}, {24'd0, exp_b});
         issue_cnt        <= issue_cnt + 1;
         start_cycles     <= start_cycles + 1;
         bus.alu_done_i   <= (alu_lat != 0) && (issue_cnt + 1 == alu_lat);
         bus.alu_result_i <= alu_force ? alu_res : ({8'h00, bus.alu_a_o} + {8'h00, bus.alu_b_o});
      end else begin
         issue_cnt        <= 0;
         bus.alu_done_i   <= 1'b0;
         bus.alu_result_i <= 16'h0000;
      end
   end

   // Monitor: pops the scoreboard on every response and checks idle invariants
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rsp_valid_o != 4'b0000) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", {28'd0, bus.rsp_valid_o}, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_valid", {28'd0, bus.rsp_valid_o}, 32'd1 << e.id);
               chk("rsp_result", {16'd0, bus.rsp_result_o}, {16'd0, e.res});
               chk("rsp_error", {31'd0, bus.rsp_error_o}, {31'd0, e.err});
            end
         end else begin
            chk("rsp_idle_zero", {15'd0, bus.rsp_error_o, bus.rsp_result_o}, 32'd0);
         end
         if (!bus.alu_start_o) begin
            chk("alu_idle_zero", {13'd0, bus.alu_opcode_o, bus.alu_a_o, bus.alu_b_o}, 32'd0);
         end
         if (bus.busy_o) begin
            chk("ready_when_busy", {28'd0, bus.req_ready_o}, 32'd0);
         end
      end
   end

   task automatic set_req(input int k, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      bus.req_valid_i[k]            = 1'b1;
      bus.req_opcode_i[k*3 +: 3]    = op;
      bus.req_a_i[k*8 +: 8]         = a;
      bus.req_b_i[k*8 +: 8]         = b;
   endtask

   task automatic clear_reqs();
      bus.req_valid_i  = 4'b0000;
      bus.req_opcode_i = 12'h000;
      bus.req_a_i      = 32'h0;
      bus.req_b_i      = 32'h0;
   endtask

   // Call right after driving inputs at a negedge; returns just after the accepting posedge.
   task automatic wait_grant(input logic [3:0] exp_ready, input int exp_id,
                             input logic [15:0] exp_res, input logic exp_err,
                             input logic [2:0] eop, input logic [7:0] ea, input logic [7:0] eb,
                             input bit push);
      bit seen;
      exp_t e;
      seen = 1'b0;
      for (int n = 0; n < 64 && !seen; n++) begin
         #1;
         if (bus.req_ready_o != 4'b0000) seen = 1'b1;
         else @(negedge clk);
      end
      chk("grant_seen", {31'd0, seen}, 32'd1);
      if (seen) begin
         chk("grant_onehot", {28'd0, bus.req_ready_o}, {28'd0, exp_ready});
         exp_op = eop;
         exp_a  = ea;
         exp_b  = eb;
         if (push) begin
            e.id = exp_id; e.res = exp_res; e.err = exp_err;
            sb.push_back(e);
         end
         @(posedge clk);
      end
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int n = 0; n < 64 && !idle; n++) begin
         @(negedge clk);
         if (!bus.busy_o) idle = 1'b1;
      end
      chk("idle_reached", {31'd0, idle}, 32'd1);
   endtask

   logic [7:0]  cont_a   [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
   logic [15:0] cont_res [5] = '{16'h0010, 16'h0021, 16'h0032, 16'h0043, 16'h0010};

   initial begin
      int sc0;
      clear_reqs();
      #2 rst = 1'b1;
      #2;
      chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("rst_start", {31'd0, bus.alu_start_o}, 32'd0);
      chk("rst_rsp_valid", {28'd0, bus.rsp_valid_o}, 32'd0);
      chk("rst_ready", {28'd0, bus.req_ready_o}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // single add from requester 2, ALU answers in the first ISSUE cycle
      alu_lat = 1;
      set_req(2, 3'd1, 8'h05, 8'h03);
      wait_grant(4'b0100, 2, 16'h0008, 1'b0, 3'd1, 8'h05, 8'h03, 1'b1);
      @(negedge clk);
      clear_reqs();
      @(negedge clk);
      chk("add_rsp_timing", {28'd0, bus.rsp_valid_o}, 32'b0100);
      wait_idle();

      // no_op from requester 1: answered the cycle after accept, ALU untouched
      sc0 = start_cycles;
      set_req(1, 3'd0, 8'hAA, 8'h55);
      wait_grant(4'b0010, 1, 16'h0000, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      @(negedge clk);
      clear_reqs();
      chk("noop_rsp_timing", {28'd0, bus.rsp_valid_o}, 32'b0010);
      wait_idle();
      chk("noop_no_start", start_cycles - sc0, 32'd0);

      // timeout: ALU never completes
      alu_lat = 0;
      sc0 = start_cycles;
      set_req(0, 3'd3, 8'h07, 8'h09);
      wait_grant(4'b0001, 0, 16'h0000, 1'b1, 3'd3, 8'h07, 8'h09, 1'b1);
      @(negedge clk);
      clear_reqs();
      wait_idle();
      chk("timeout_start_cycles", start_cycles - sc0, 32'd16);

      // done arrives on the 16th ISSUE cycle and must beat the timeout
      alu_lat = 16;
      alu_force = 1'b1;
      alu_res = 16'h00F0;
      sc0 = start_cycles;
      set_req(1, 3'd2, 8'h0F, 8'h10);
      wait_grant(4'b0010, 1, 16'h00F0, 1'b0, 3'd2, 8'h0F, 8'h10, 1'b1);
      @(negedge clk);
      clear_reqs();
      wait_idle();
      chk("done_on_timeout_cycles", start_cycles - sc0, 32'd16);
      alu_force = 1'b0;

      // reset in the second ISSUE cycle of a multiply; rr pointer sits at 2 beforehand
      alu_lat = 0;
      set_req(1, 3'd3, 8'h03, 8'h04);
      wait_grant(4'b0010, 1, 16'h0000, 1'b0, 3'd3, 8'h03, 8'h04, 1'b0);
      @(posedge clk);
      #1;
      chk("mul_start_before_rst", {31'd0, bus.alu_start_o}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_async_start", {31'd0, bus.alu_start_o}, 32'd0);
      chk("rst_async_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("rst_async_rsp", {28'd0, bus.rsp_valid_o}, 32'd0);
      @(negedge clk);
      clear_reqs();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // contention: all four valid continuously, grants 0,1,2,3,0
      alu_lat = 1;
      for (int k = 0; k < 4; k++) set_req(k, 3'd1, cont_a[k], 8'(k));
      for (int g = 0; g < 5; g++) begin
         wait_grant(4'b0001 << (g % 4), g % 4, cont_res[g], 1'b0,
                    3'd1, cont_a[g % 4], 8'(g % 4), 1'b1);
      end
      @(negedge clk);
      clear_reqs();
      wait_idle();

      for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
